// File: rtl/uram512_port_arb_if.sv
// Bundle of the requester-side and URAM-side signals of uram512_port_arb.
// Build option: URAM_ARB_STATS_EN (the statistics ports live on the arbiter, not here).
//   req_*     : per-requester beat handshake, command fields flattened by requester index
//   mem_*     : URAM port B pins (en/rdb_wr/addr/bwe/din driven, dout returned)
//   rsp_*     : read-data return, tagged with the issuing requester
//   busy      : owner locked or read in flight
// Modport slave is taken by the arbiter; master is the environment (DMA engines + URAM).
interface uram512_port_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned DATA_W  = 576,
  parameter int unsigned BWE_W   = 9
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*BWE_W-1:0]  req_bwe;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  logic                      mem_en;
  logic                      mem_rdb_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [BWE_W-1:0]          mem_bwe;
  logic [DATA_W-1:0]         mem_din;
  logic [DATA_W-1:0]         mem_dout;

  logic                      rsp_valid;
  logic [IdW-1:0]            rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  modport slave (
    input  req_valid, req_wr, req_last, req_addr, req_bwe, req_data, mem_dout,
    output req_ready, mem_en, mem_rdb_wr, mem_addr, mem_bwe, mem_din,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_wr, req_last, req_addr, req_bwe, req_data, mem_dout,
    input  req_ready, mem_en, mem_rdb_wr, mem_addr, mem_bwe, mem_din,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/uram512_port_arb.sv
// Shares one 576-bit URAM port between NUM_REQ requesters.
// Round-robin arbitration with burst hold (up to MAX_BURST beats per grant), registered command
// into the port, and read data returned to the issuing requester after RD_LAT cycles.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : uram512_port_arb_if.slave (requester handshake, URAM pins, response, busy)
// Build option URAM_ARB_STATS_EN adds:
//   stat_clr   : synchronous clear of all counters (wins over increment)
//   stat_beats : per-requester accepted-beat counters, 32 bits each, requester i at [i*32 +: 32]
//   stat_stall : per-requester valid-but-not-ready cycle counters, same layout
module uram512_port_arb #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned DATA_W    = 576,
  parameter int unsigned BWE_W     = 9,
  parameter int unsigned RD_LAT    = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  uram512_port_arb_if.slave       bus
`ifdef URAM_ARB_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_REQ*32-1:0]   stat_beats,
  output logic [NUM_REQ*32-1:0]   stat_stall
`endif
);

  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e                       state_q, state_d;
  logic [IdW-1:0]               owner_q, owner_d;
  logic [IdW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]              beat_cnt_q, beat_cnt_d;

  logic                         mem_en_q, mem_en_d;
  logic                         mem_rdb_wr_q, mem_rdb_wr_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [BWE_W-1:0]             mem_bwe_q, mem_bwe_d;
  logic [DATA_W-1:0]            mem_din_q, mem_din_d;
  logic [IdW-1:0]               mem_id_q, mem_id_d;

  // Read-return pipeline: stage 0 is loaded from the registered command, so the last stage
  // lines up with mem_dout RD_LAT cycles after mem_en.
  logic [RD_LAT-1:0]            rd_v_q, rd_v_d;
  logic [RD_LAT-1:0][IdW-1:0]   rd_id_q, rd_id_d;

  logic [IdW-1:0]               winner, scan_idx, sel;
  logic                         found, accept;
  logic [NUM_REQ-1:0]           ready;

  logic [ADDR_W-1:0]            addr_arr [NUM_REQ];
  logic [BWE_W-1:0]             bwe_arr  [NUM_REQ];
  logic [DATA_W-1:0]            data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign bwe_arr[g]  = bus.req_bwe[g*BWE_W +: BWE_W];
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == StLocked) begin
      ready[owner_q] = bus.req_valid[owner_q];
    end else if (found) begin
      ready[winner] = 1'b1;
    end
    sel    = (state_q == StLocked) ? owner_q : winner;
    accept = |(bus.req_valid & ready);
  end

  // Lock / release and command register next state.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    mem_en_d     = accept;
    mem_rdb_wr_d = mem_rdb_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_bwe_d    = mem_bwe_q;
    mem_din_d    = mem_din_q;
    mem_id_d     = mem_id_q;
    if (accept) begin
      mem_rdb_wr_d = bus.req_wr[sel];
      mem_addr_d   = addr_arr[sel];
      mem_bwe_d    = bwe_arr[sel];
      mem_din_d    = data_arr[sel];
      mem_id_d     = sel;
      if (bus.req_last[sel] || ((beat_cnt_q + 1'b1) >= BurstMax)) begin
        state_d    = StUnlocked;
        beat_cnt_d = '0;
        rr_ptr_d   = (sel == LastId) ? '0 : sel + 1'b1;
      end else begin
        state_d    = StLocked;
        owner_d    = sel;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_v_d     = rd_v_q;
    rd_id_d    = rd_id_q;
    rd_v_d[0]  = mem_en_q & ~mem_rdb_wr_q;
    rd_id_d[0] = mem_id_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rd_v_d[i]  = rd_v_q[i-1];
      rd_id_d[i] = rd_id_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StUnlocked;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_rdb_wr_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_bwe_q    <= '0;
      mem_din_q    <= '0;
      mem_id_q     <= '0;
      rd_v_q       <= '0;
      rd_id_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_rdb_wr_q <= mem_rdb_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_bwe_q    <= mem_bwe_d;
      mem_din_q    <= mem_din_d;
      mem_id_q     <= mem_id_d;
      rd_v_q       <= rd_v_d;
      rd_id_q      <= rd_id_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_rdb_wr = mem_rdb_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_bwe    = mem_bwe_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.rsp_valid  = rd_v_q[RD_LAT-1];
  assign bus.rsp_id     = rd_id_q[RD_LAT-1];
  assign bus.rsp_data   = bus.mem_dout;
  assign bus.busy       = (state_q == StLocked) | (|rd_v_q);

`ifdef URAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] beats_q, beats_d;
  logic [NUM_REQ-1:0][31:0] stall_q, stall_d;

  always_comb begin
    beats_d = beats_q;
    stall_d = stall_q;
    if (stat_clr) begin
      beats_d = '0;
      stall_d = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && ready[i])  beats_d[i] = beats_q[i] + 32'd1;
        if (bus.req_valid[i] && !ready[i]) stall_d[i] = stall_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_uram512_port_arb.sv
// Self-checking bench for uram512_port_arb: behavioural URAM with RD_LAT read latency,
// scoreboard of expected command/response, table-driven single beats, and sequences for
// round-robin, burst hold, owner gap and reset with reads in flight.
module tb_uram512_port_arb;
  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned ADDR_W    = 23;
  localparam int unsigned DATA_W    = 576;
  localparam int unsigned BWE_W     = 9;
  localparam int unsigned RD_LAT    = 3;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned LANE_W    = DATA_W / BWE_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uram512_port_arb_if #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BWE_W(BWE_W)
  ) bus ();

`ifdef URAM_ARB_STATS_EN
  logic                  stat_clr = 1'b0;
  logic [NUM_REQ*32-1:0] stat_beats;
  logic [NUM_REQ*32-1:0] stat_stall;
`endif

  uram512_port_arb #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BWE_W(BWE_W),
    .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef URAM_ARB_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_beats(stat_beats),
    .stat_stall(stat_stall)
`endif
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BWE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int l = 0; l < BWE_W; l++) if (be[l]) r[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
    return r;
  endfunction

  // Behavioural URAM (low 8 address bits only).
  logic [DATA_W-1:0] ram  [256] = '{default: '0};
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_rdb_wr)
      ram[bus.mem_addr[7:0]] <= merge(ram[bus.mem_addr[7:0]], bus.mem_din, bus.mem_bwe);
    pipe[0] <= (bus.mem_en && !bus.mem_rdb_wr) ? ram[bus.mem_addr[7:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_dout = pipe[RD_LAT-1];

  // Scoreboard state.
  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rsp_t;
  rsp_t              rsp_q[$];
  logic [DATA_W-1:0] shadow [256] = '{default: '0};
  logic              exp_mem_v = 1'b0;
  logic              exp_wr;
  logic [ADDR_W-1:0] exp_addr;
  logic [BWE_W-1:0]  exp_bwe;
  logic [DATA_W-1:0] exp_din;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Runs at every falling edge: checks last cycle's command, pops responses, logs new accepts.
  task automatic monitor_step();
    logic [NUM_REQ-1:0] acc;
    rsp_t               r;
    logic [7:0]         a;
    if (rst) begin
      rsp_q.delete();
      exp_mem_v = 1'b0;
      return;
    end
    chk("mem_en", bus.mem_en, exp_mem_v);
    if (exp_mem_v) begin
      chk("mem_rdb_wr", bus.mem_rdb_wr, exp_wr);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_bwe", bus.mem_bwe, exp_bwe);
      chk("mem_din", bus.mem_din, exp_din);
    end
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected @cyc %0d: rsp_valid=1 id=%0d, expected no response",
                 cyc, bus.rsp_id);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_id", bus.rsp_id, r.id);
        chk("rsp_data", bus.rsp_data, r.data);
        chk("rsp_cycle", cyc, r.cyc);
      end
    end
    acc = bus.req_valid & bus.req_ready;
    chk("ready_onehot", ($countones(acc) <= 1), 1'b1);
    exp_mem_v = (acc != '0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        exp_wr   = bus.req_wr[i];
        exp_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        exp_bwe  = bus.req_bwe[i*BWE_W +: BWE_W];
        exp_din  = bus.req_data[i*DATA_W +: DATA_W];
        a        = exp_addr[7:0];
        if (exp_wr) shadow[a] = merge(shadow[a], exp_din, exp_bwe);
        else rsp_q.push_back('{id: i, data: shadow[a], cyc: cyc + RD_LAT + 1});
      end
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_last  = '0;
    bus.req_addr  = '0;
    bus.req_bwe   = '0;
    bus.req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic last,
                         input logic [ADDR_W-1:0] addr, input logic [BWE_W-1:0] be,
                         input logic [7:0] pat);
    logic [DATA_W-1:0] d;
    d = {72{pat}};
    bus.req_valid[i]                     = 1'b1;
    bus.req_wr[i]                        = wr;
    bus.req_last[i]                      = last;
    bus.req_addr[i*ADDR_W +: ADDR_W]     = addr;
    bus.req_bwe[i*BWE_W +: BWE_W]        = be;
    bus.req_data[i*DATA_W +: DATA_W]     = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.req_ready, '0);
    chk({tag, "_mem_en"}, bus.mem_en, 1'b0);
    chk({tag, "_rdb_wr"}, bus.mem_rdb_wr, 1'b0);
    chk({tag, "_addr"}, bus.mem_addr, '0);
    chk({tag, "_bwe"}, bus.mem_bwe, '0);
    chk({tag, "_din"}, bus.mem_din, '0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, bus.rsp_id, '0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
`ifdef URAM_ARB_STATS_EN
    chk({tag, "_stat_beats"}, stat_beats, '0);
    chk({tag, "_stat_stall"}, stat_stall, '0);
`endif
  endtask

  // Entered and left at posedge+1.
  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && rsp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int                 req;
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [BWE_W-1:0]   bwe;
    logic [7:0]         pat;
    logic [NUM_REQ-1:0] exp_ready;
  } vec_t;
  vec_t vecs[7];

  logic [NUM_REQ-1:0] bseq[7];
  int rem0, rem1;

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
      end
    join_none

    vecs[0] = '{req: 0, wr: 1'b1, addr: 23'h10, bwe: 9'h1FF, pat: 8'hA5, exp_ready: 2'b01};
    vecs[1] = '{req: 1, wr: 1'b1, addr: 23'h20, bwe: 9'h0F3, pat: 8'h3C, exp_ready: 2'b10};
    vecs[2] = '{req: 1, wr: 1'b0, addr: 23'h10, bwe: 9'h000, pat: 8'h00, exp_ready: 2'b10};
    vecs[3] = '{req: 0, wr: 1'b0, addr: 23'h20, bwe: 9'h000, pat: 8'h00, exp_ready: 2'b01};
    vecs[4] = '{req: 0, wr: 1'b0, addr: 23'h33, bwe: 9'h000, pat: 8'h00, exp_ready: 2'b01};
    vecs[5] = '{req: 1, wr: 1'b1, addr: 23'h10, bwe: 9'h001, pat: 8'h5A, exp_ready: 2'b10};
    vecs[6] = '{req: 0, wr: 1'b0, addr: 23'h10, bwe: 9'h000, pat: 8'h00, exp_ready: 2'b01};

    clear_reqs();
    @(negedge clk);
    chk_reset_vals("init");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single-beat table, one beat per cycle, back-to-back.
    foreach (vecs[i]) begin
      clear_reqs();
      set_req(vecs[i].req, vecs[i].wr, 1'b1, vecs[i].addr, vecs[i].bwe, vecs[i].pat);
      @(negedge clk);
      chk("vec_ready", bus.req_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
    end
    clear_reqs();
    drain();

    // Back-to-back reads from requester 1.
    for (int i = 0; i < 3; i++) begin
      clear_reqs();
      set_req(1, 1'b0, 1'b1, (i == 0) ? 23'h10 : (i == 1) ? 23'h20 : 23'h33, '0, 8'h00);
      @(negedge clk);
      chk("b2b_ready", bus.req_ready, 2'b10);
      @(posedge clk);
      #1;
    end
    clear_reqs();
    drain();

    // Round-robin: both valid, single-beat bursts.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clear_reqs();
      set_req(0, 1'b1, 1'b1, 23'h60 + 23'(c), 9'h1FF, 8'h11);
      set_req(1, 1'b1, 1'b1, 23'h70 + 23'(c), 9'h1FF, 8'h22);
      @(negedge clk);
      chk("rr_ready", bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk);
      #1;
    end

    // Burst hold: six req0 beats without last, req1 waiting with one beat.
    do_reset();
    bseq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    rem0 = 6;
    rem1 = 1;
    for (int c = 0; c < 7; c++) begin
      clear_reqs();
      if (rem0 > 0) set_req(0, 1'b1, 1'b0, 23'h40 + 23'(c), 9'h1FF, 8'h44);
      if (rem1 > 0) set_req(1, 1'b1, 1'b1, 23'h50, 9'h1FF, 8'h55);
      @(negedge clk);
      chk("burst_ready", bus.req_ready, bseq[c]);
      if (bus.req_ready[0]) rem0--;
      if (bus.req_ready[1]) rem1--;
      @(posedge clk);
      #1;
    end
    clear_reqs();
    @(negedge clk);
    chk("burst_busy_locked", bus.busy, 1'b1);
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b1, 23'h48, 9'h1FF, 8'h44);
    @(negedge clk);
    chk("burst_close_ready", bus.req_ready, 2'b01);
    @(posedge clk);
    #1 clear_reqs();
    @(negedge clk);
    chk("burst_busy_released", bus.busy, 1'b0);
    @(posedge clk);
    #1;

    // Owner gap: locked req0 idles three cycles, req1 must stall.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_reqs();
      if (c == 0) set_req(0, 1'b1, 1'b0, 23'h80, 9'h1FF, 8'h66);
      if (c == 4) set_req(0, 1'b1, 1'b1, 23'h81, 9'h1FF, 8'h67);
      set_req(1, 1'b1, 1'b1, 23'h90, 9'h1FF, 8'h77);
      @(negedge clk);
      chk("gap_ready", bus.req_ready, (c == 0 || c == 4) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00);
      if (c >= 1 && c <= 3) chk("gap_busy", bus.busy, 1'b1);
      @(posedge clk);
      #1;
    end
    clear_reqs();
`ifdef URAM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_beats_gap", stat_beats, {32'd1, 32'd2});
    chk("stat_stall_gap", stat_stall, {32'd5, 32'd0});
    @(posedge clk);
    #1;
    stat_clr = 1'b1;
    set_req(1, 1'b1, 1'b1, 23'h91, 9'h1FF, 8'h78);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    clear_reqs();
    @(negedge clk);
    chk("stat_beats_clr", stat_beats, '0);
    chk("stat_stall_clr", stat_stall, '0);
    @(posedge clk);
    #1;
`endif

    // Reset with three reads in flight: none may ever respond.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_reqs();
      set_req(0, 1'b0, 1'b1, 23'h10, '0, 8'h00);
      @(negedge clk);
      chk("rstrd_ready", bus.req_ready, 2'b01);
      @(posedge clk);
      #1;
    end
    clear_reqs();
    @(negedge clk);
    chk("rstrd_busy", bus.busy, 1'b1);
`ifdef URAM_ARB_STATS_EN
    chk("stat_beats_rd", stat_beats, {32'd0, 32'd3});
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("postrst_rsp_valid", bus.rsp_valid, 1'b0);
    end
    chk_reset_vals("postrst");
    chk("final_pending", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
